// File: rtl/instr_encoder.sv
// Streaming RISC-V instruction encoder: packs I-ALU/I-load/S/SB fields into a 32-bit word, range-checks
// the immediate and tags each word with a byte address. Optional ENC_SHIFT_CHECK_EN validates shift amounts.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              out_last,
  output logic              done,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(4);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [31:0]       NOP      = 32'h0000_0013;
  localparam logic [6:0]        OP_IALU  = 7'b0010011;
  localparam logic [6:0]        OP_ILOAD = 7'b0000011;
  localparam logic [6:0]        OP_S     = 7'b0100011;
  localparam logic [6:0]        OP_SB    = 7'b1100011;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              r_last;
  logic              r_done;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_addr_cnt;

  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_fits12;
  logic              w_fits13_even;
  logic              w_range_ok;
  logic              w_imm_ok;
  logic [31:0]       w_enc;
  logic [31:0]       w_word;

  assign in_ready  = !r_valid || out_ready;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_valid && out_ready;

  // Sign-extension tests: the upper bits must all equal the field's sign bit.
  assign w_fits12      = (in_imm[31:11] == {21{in_imm[11]}});
  assign w_fits13_even = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign w_range_ok    = (in_fmt == 2'd3) ? w_fits13_even : w_fits12;

`ifdef ENC_SHIFT_CHECK_EN
  logic w_is_shift;
  logic w_shamt_ok;

  assign w_is_shift = (in_fmt == 2'd0) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign w_shamt_ok = (in_imm[31:12] == 20'd0) &&
                      ((in_imm[11:5] == 7'b0000000) ||
                       ((in_funct3 == 3'b101) && (in_imm[11:5] == 7'b0100000)));
  assign w_imm_ok   = w_is_shift ? w_shamt_ok : w_range_ok;
`else
  assign w_imm_ok   = w_range_ok;
`endif

  always_comb begin
    w_enc = NOP;
    case (in_fmt)
      2'd0: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
      2'd1: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ILOAD};
      2'd2: w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      default: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_SB};
    endcase
  end

  assign w_word = w_imm_ok ? w_enc : NOP;

  // Output register: a new word may load in the same cycle the old one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_addr     <= BASE;
      r_err      <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err_cnt  <= '0;
      r_addr_cnt <= BASE;
    end else begin
      r_done <= w_out_hs && r_last;
      if (w_out_hs && r_err && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_in_hs) begin
        r_valid    <= 1'b1;
        r_instr    <= w_word;
        r_addr     <= r_addr_cnt;
        r_err      <= !w_imm_ok;
        r_last     <= in_last;
        r_addr_cnt <= in_last ? BASE : (r_addr_cnt + STEP);
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign out_err   = r_err;
  assign out_last  = r_last;
  assign done      = r_done;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic against a
// field-arithmetic reference model. Define ENC_SHIFT_CHECK_EN to match a DUT built with that macro.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int ERR_W  = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic              out_last;
  logic              done;
  logic [ERR_W-1:0]  err_count;

  int n_cmp;
  int n_fail;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .out_last(out_last), .done(done), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: fields placed by arithmetic shifts, validity decided on the signed integer value.
  function automatic logic [31:0] ref_encode(input logic [1:0] fmt, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm,
                                             output logic err);
    int signed   si;
    logic [31:0] u;
    logic [31:0] op;
    logic [31:0] common;
    logic [31:0] w;
    bit          ok;
    si = $signed(imm);
    u  = imm;
    case (fmt)
      2'd0: op = 32'h13;
      2'd1: op = 32'h03;
      2'd2: op = 32'h23;
      default: op = 32'h63;
    endcase
    if (fmt == 2'd3) ok = (si >= -4096) && (si <= 4094) && ((u % 2) == 0);
    else             ok = (si >= -2048) && (si <= 2047);
`ifdef ENC_SHIFT_CHECK_EN
    if (fmt == 2'd0 && (f3 == 3'd1 || f3 == 3'd5))
      ok = ((u >> 12) == 0) &&
           ((((u >> 5) & 32'h7F) == 0) || (f3 == 3'd5 && ((u >> 5) & 32'h7F) == 32));
`endif
    common = (32'(f3) << 12) | (32'(rs1) << 15);
    case (fmt)
      2'd0, 2'd1: w = ((u & 32'hFFF) << 20) | common | (32'(rd) << 7) | op;
      2'd2: w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | common | ((u & 32'h1F) << 7) | op;
      default: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
                   common | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | op;
    endcase
    err = !ok;
    return ok ? w : 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rand_imm();
    int bvals[12];
    int sel;
    bvals = '{-2049, -2048, 2047, 2048, -4096, -4097, -4098, 4094, 4095, 4096, 3, -3};
    sel = $urandom_range(0, 4);
    case (sel)
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return 32'(bvals[$urandom_range(0, 11)]);
      2: return $urandom();
      3: return {20'd0, ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom_range(0, 31))};
      default: return 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                           input logic last);
    in_valid = 1'b1; in_fmt = fmt; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    do_reset();
    out_ready = 1'b1;
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    $display("txn addi addr=%0d instr=%h err=%b", out_addr, out_instr, out_err);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL addi_instr: got %h want 00500093", out_instr); end
    n_cmp++; if (out_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL addi_addr: got %0d want %0d", out_addr, BASE); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL addi_err: got %b want 0", out_err); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive_req(2'd1, 3'd2, 5'd2, 5'd1, 5'd0, 32'd8, 1'b0);
    tick();
    $display("txn lw addr=%0d instr=%h", out_addr, out_instr);
    n_cmp++; if (out_instr !== 32'h0080_A103) begin n_fail++; $display("FAIL b2b_lw: got %h want 0080a103", out_instr); end
    n_cmp++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL b2b_lw_addr: got %0d want 0", out_addr); end
    drive_req(2'd2, 3'd2, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0);
    tick();
    in_valid = 1'b0;
    $display("txn sw addr=%0d instr=%h", out_addr, out_instr);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_instr !== 32'h0020_A623) begin n_fail++; $display("FAIL b2b_sw: got %h want 0020a623", out_instr); end
    n_cmp++; if (out_addr !== 10'd4) begin n_fail++; $display("FAIL b2b_sw_addr: got %0d want 4", out_addr); end
    tick();
  endtask

  task automatic test_branch_err();
    do_reset();
    out_ready = 1'b1;
    drive_req(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0);
    tick();
    $display("txn beq addr=%0d instr=%h err=%b", out_addr, out_instr, out_err);
    n_cmp++; if (out_instr !== 32'hFE20_8CE3) begin n_fail++; $display("FAIL beq_instr: got %h want fe208ce3", out_instr); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL beq_err: got %b want 0", out_err); end
    drive_req(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    tick();
    n_cmp++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL sb_odd_instr: got %h want 00000013", out_instr); end
    n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL sb_odd_err: got %b want 1", out_err); end
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL addi_big_instr: got %h want 00000013", out_instr); end
    n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL addi_big_err: got %b want 1", out_err); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL errcnt_mid: got %0d want 1", err_count); end
    tick();
    n_cmp++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL errcnt_two: got %0d want 2", err_count); end
  endtask

  task automatic test_stall();
    logic [31:0] w0, w1;
    logic        e;
    do_reset();
    w0 = ref_encode(2'd0, 3'd0, 5'd1, 5'd2, 5'd0, 32'd7, e);
    w1 = ref_encode(2'd0, 3'd4, 5'd3, 5'd4, 5'd0, 32'd9, e);
    drive_req(2'd0, 3'd0, 5'd1, 5'd2, 5'd0, 32'd7, 1'b0);
    tick();
    drive_req(2'd0, 3'd4, 5'd3, 5'd4, 5'd0, 32'd9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", k, in_ready); end
      tick();
      n_cmp++; if (out_instr !== w0) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", k, out_instr, w0); end
      n_cmp++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d want 0", k, out_addr); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    $display("txn stall_release addr=%0d instr=%h", out_addr, out_instr);
    n_cmp++; if (out_instr !== w1) begin n_fail++; $display("FAIL release_instr: got %h want %h", out_instr, w1); end
    n_cmp++; if (out_addr !== 10'd4) begin n_fail++; $display("FAIL release_addr: got %0d want 4", out_addr); end
    tick();
  endtask

  task automatic test_program();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_req(2'd0, 3'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k), (k == 2));
      tick();
      $display("txn prog[%0d] addr=%0d last=%b", k, out_addr, out_last);
      n_cmp++; if (out_addr !== 10'(4 * k)) begin n_fail++; $display("FAIL prog_addr[%0d]: got %0d want %0d", k, out_addr, 4 * k); end
      n_cmp++; if (out_last !== (k == 2)) begin n_fail++; $display("FAIL prog_last[%0d]: got %b want %b", k, out_last, (k == 2)); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL prog_done_early[%0d]: got %b want 0", k, done); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL prog_done: got %b want 1", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL prog_done_width: got %b want 0", done); end
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL prog_reload: got %0d want %0d", out_addr, BASE); end
    tick();
  endtask

  task automatic test_reset_pending();
    do_reset();
    out_ready = 1'b1;
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5000, 1'b0);
    tick();
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd6, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL rstp_pre_errcnt: got %0d want 1", err_count); end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstp_valid: got %b want 0", out_valid); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rstp_errcnt: got %0d want 0", err_count); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstp_done: got %b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstp_done_late: got %b want 0", done); end
    // counter away from base, then reset with a word still pending
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    tick();
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2, 1'b0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    drive_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL rstp_addr: got %0d want %0d", out_addr, BASE); end
    tick();
  endtask

  task automatic test_saturate();
    int exp_addr;
    do_reset();
    out_ready = 1'b1;
    exp_addr = BASE;
    for (int k = 0; k < 300; k++) begin
      drive_req(2'd2, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 1'b0);
      tick();
      n_cmp++; if (out_addr !== ADDR_W'(exp_addr)) begin n_fail++; $display("FAIL sat_addr[%0d]: got %0d want %0d", k, out_addr, exp_addr); end
      exp_addr = (exp_addr + 4) % (1 << ADDR_W);
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_errcnt: got %0d want 255", err_count); end
  endtask

  task automatic test_shift();
    logic [31:0] want_srli;
    logic        want_srli_err;
    do_reset();
    out_ready = 1'b1;
    drive_req(2'd0, 3'd5, 5'd1, 5'd1, 5'd0, 32'h405, 1'b0);
    tick();
    $display("txn srai addr=%0d instr=%h err=%b", out_addr, out_instr, out_err);
    n_cmp++; if (out_instr !== 32'h4050_D093) begin n_fail++; $display("FAIL srai_instr: got %h want 4050d093", out_instr); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL srai_err: got %b want 0", out_err); end
`ifdef ENC_SHIFT_CHECK_EN
    want_srli = 32'h0000_0013; want_srli_err = 1'b1;
`else
    want_srli = 32'h2050_D093; want_srli_err = 1'b0;
`endif
    drive_req(2'd0, 3'd5, 5'd1, 5'd1, 5'd0, 32'h205, 1'b0);
    tick();
    in_valid = 1'b0;
    $display("txn srli addr=%0d instr=%h err=%b", out_addr, out_instr, out_err);
    n_cmp++; if (out_instr !== want_srli) begin n_fail++; $display("FAIL srli_instr: got %h want %h", out_instr, want_srli); end
    n_cmp++; if (out_err !== want_srli_err) begin n_fail++; $display("FAIL srli_err: got %b want %b", out_err, want_srli_err); end
    tick();
  endtask

  task automatic test_random(input int cycles);
    bit          m_valid, m_err, m_last, m_done;
    logic [31:0] m_instr;
    int          m_aout, m_cnt, m_errcnt;
    bit          rdy, ihs, ohs;
    logic [31:0] w;
    logic        e;
    do_reset();
    m_valid = 0; m_err = 0; m_last = 0; m_done = 0; m_instr = 0;
    m_aout = BASE; m_cnt = BASE; m_errcnt = 0;
    for (int c = 0; c < cycles; c++) begin
      n_cmp++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (out_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", c, out_instr, m_instr); end
        n_cmp++; if (out_addr !== ADDR_W'(m_aout)) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", c, out_addr, m_aout); end
        n_cmp++; if (out_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", c, out_err, m_err); end
        n_cmp++; if (out_last !== m_last) begin n_fail++; $display("FAIL rnd_last[%0d]: got %b want %b", c, out_last, m_last); end
      end
      n_cmp++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done[%0d]: got %b want %b", c, done, m_done); end
      n_cmp++; if (err_count !== ERR_W'(m_errcnt)) begin n_fail++; $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", c, err_count, m_errcnt); end
      drive_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rand_imm(),
                ($urandom_range(0, 9) == 0));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy = !m_valid || out_ready;
      n_cmp++; if (in_ready !== rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, rdy); end
      ihs = in_valid && rdy;
      ohs = m_valid && out_ready;
      m_done = ohs && m_last;
      if (ohs && m_err && m_errcnt < (1 << ERR_W) - 1) m_errcnt++;
      if (ihs) begin
        w = ref_encode(in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm, e);
        m_valid = 1; m_instr = w; m_err = e; m_last = in_last; m_aout = m_cnt;
        m_cnt = in_last ? BASE : (m_cnt + 4) % (1 << ADDR_W);
      end else if (ohs) begin
        m_valid = 0;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_fmt = 2'd0; in_funct3 = 3'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; in_last = 1'b0;
    #2;
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_err();
    test_stall();
    test_program();
    test_reset_pending();
    test_saturate();
    test_shift();
    test_random(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V instruction encoder: the inverse of the datapath immediate generator.
- Packs opcode class, funct3, register indices and a 32-bit signed immediate into a 32-bit instruction word for I-ALU, I-load, S and SB formats.
- Range-checks the immediate and tags each word with a byte address.
- Used by the test/boot loader to write programs into instruction memory via a valid/ready stream.

Parameters:
- ADDR_W, 10, width of the output byte address; wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, first address emitted after reset and after each `done`; must be a multiple of 4.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_fmt  in  2  format select: 0=I-ALU (0010011), 1=I-load (0000011), 2=S (0100011), 3=SB (1100011).
- in_funct3  in  3  funct3 field.
- in_rd  in  5  destination register; ignored for S and SB.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2; ignored for I-ALU and I-load.
- in_imm  in  32  signed immediate; byte offset for SB.
- in_last  in  1  marks the final instruction of a program.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- out_err  out  1  word was replaced because the immediate was out of range.
- out_last  out  1  registered copy of in_last.
- done  out  1  one-cycle pulse after the last word is accepted.
- err_count  out  ERR_W  saturating count of errored words.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_instr=0, out_err=0, out_last=0, done=0, err_count=0.
  - Address counter = BASE_ADDR.
  - Any held output word is discarded. Reset has priority over every other event.
- Handshakes:
  - Input handshake = in_valid & in_ready. Output handshake = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational).
  - Single output register; latency 1 cycle from input handshake to out_valid.
  - Full throughput when out_ready is held at 1.
- Output stability:
  - While out_valid=1 and out_ready=0, out_instr, out_addr, out_err and out_last hold stable.
  - No new request is accepted in that condition.
- Encoding, written into the output register on input handshake:
  - I-ALU / I-load: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Range check, using the full 32-bit in_imm:
  - I and S formats: in_imm must lie in -2048..2047.
  - SB format: in_imm must lie in -4096..4094 and in_imm[0] must be 0.
  - On violation: out_instr=0x00000013 (NOP) and out_err=1.
  - err_count increments on the output handshake of an errored word and saturates at all-ones.
- Address counter:
  - out_addr is the counter value captured at the input handshake.
  - Counter += 4 on each input handshake, wrapping modulo 2^ADDR_W.
  - If in_last=1 at the input handshake, the counter reloads BASE_ADDR instead of incrementing.
- done:
  - Asserted for exactly one cycle, in the cycle after the output handshake of a word with out_last=1.
  - Otherwise 0.
- Simultaneous output handshake and new input handshake in the same cycle: the register loads the new word and out_valid stays 1.
- rst asserted while a word is pending: the word is dropped, no done pulse, err_count is cleared.

Optional Feature:
- Macro: ENC_SHIFT_CHECK_EN.
- When defined, for in_fmt=0 with funct3=001 (slli) or funct3=101 (srli/srai), the word is errored (NOP, out_err=1, counted) unless:
  - in_imm[31:12]=0;
  - in_imm[11:5]=0000000, or additionally 0100000 when funct3=101.
- When not defined, shifts use only the generic I-format range check.

Test Plan:
- addi x1,x0,5 (fmt0, f3=0, rd=1, rs1=0, imm=5) after reset -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0, out_err=0.
- Back-to-back with out_ready=1: lw x2,8(x1) then sw x2,12(x1) -> 0x0080A103 at addr 0, then 0x0020A623 at addr 4, one word per cycle.
- beq x1,x2,-8 (fmt3, imm=0xFFFFFFF8) -> 0xFE208CE3. Then SB with imm=3 and addi with imm=4096 -> both give 0x00000013 with out_err=1; err_count=2 after both are accepted.
- out_ready=0 for 3 cycles with a word pending -> out_instr/out_addr stable, in_ready=0, no input accepted. Release -> word accepted, next request accepted in the same cycle.
- Program of 3 words with in_last on the third -> addrs 0,4,8; done pulses once the cycle after the third is accepted; next word gets addr BASE_ADDR.
- rst asserted while out_valid=1 -> next cycle out_valid=0, err_count=0, next address = BASE_ADDR, no done pulse.
- With ENC_SHIFT_CHECK_EN: srai with imm=0x405 -> 0x4050D093-style word with out_err=0 (rd=1, rs1=1); srli with imm=0x205 -> NOP with out_err=1.
